// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: holds predicted branches until EX resolves them, flags mispredicts
// and drives predictor training. Define BRQ_STATS_EN to add resolved/mispredict counters.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [PC_W-1:0]  push_pc,
    input  logic             push_pred,
    input  logic [PC_W-1:0]  push_target,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count,
    input  logic             resolve,
    input  logic             resolve_taken,
    input  logic [PC_W-1:0]  resolve_target,
    output logic             mispredict,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             upd_valid,
    output logic [PC_W-1:0]  upd_pc,
    output logic             upd_outcome,
`ifdef BRQ_STATS_EN
    output logic [15:0]      stat_resolved,
    output logic [15:0]      stat_mispred,
`endif
    output logic             underflow
);

    logic [PC_W-1:0]  pc_mem  [DEPTH];
    logic             pred_mem[DEPTH];
    logic [PC_W-1:0]  tgt_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic             do_pop;
    logic             do_push;
    logic             flush;
    logic [PC_W-1:0]  head_pc;
    logic             head_pred;
    logic [PC_W-1:0]  head_tgt;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

    assign head_pc   = pc_mem[rd_ptr];
    assign head_pred = pred_mem[rd_ptr];
    assign head_tgt  = tgt_mem[rd_ptr];

    // A wrong direction, or a right "taken" with the wrong target, both redirect fetch.
    always_comb begin
        do_pop  = resolve && !empty;
        flush   = do_pop && ((resolve_taken != head_pred) ||
                             (resolve_taken && head_pred && (resolve_target != head_tgt)));
        do_push = push && (!full || do_pop) && !flush;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr]   <= push_pc;
            pred_mem[wr_ptr] <= push_pred;
            tgt_mem[wr_ptr]  <= push_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            upd_valid   <= 1'b0;
            upd_pc      <= '0;
            upd_outcome <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
            end

            upd_valid  <= do_pop;
            mispredict <= flush;
            if (do_pop) begin
                upd_pc      <= head_pc;
                upd_outcome <= resolve_taken;
            end
            if (flush)
                redirect_pc <= resolve_taken ? resolve_target : head_pc + PC_W'(4);
            if (resolve && empty)
                underflow <= 1'b1;
        end
    end

`ifdef BRQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_resolved <= '0;
            stat_mispred  <= '0;
        end else begin
            if (do_pop && stat_resolved != 16'hFFFF) stat_resolved <= stat_resolved + 16'd1;
            if (flush  && stat_mispred  != 16'hFFFF) stat_mispred  <= stat_mispred + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios then random traffic against a
// queue-based reference model.
module tb_branch_resolve_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int PC_W  = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             push;
    logic [PC_W-1:0]  push_pc;
    logic             push_pred;
    logic [PC_W-1:0]  push_target;
    logic             full;
    logic             empty;
    logic [PTR_W:0]   count;
    logic             resolve;
    logic             resolve_taken;
    logic [PC_W-1:0]  resolve_target;
    logic             mispredict;
    logic [PC_W-1:0]  redirect_pc;
    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic             upd_outcome;
    logic             underflow;
`ifdef BRQ_STATS_EN
    logic [15:0]      stat_resolved;
    logic [15:0]      stat_mispred;
`endif

    branch_resolve_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset),
        .push(push), .push_pc(push_pc), .push_pred(push_pred), .push_target(push_target),
        .full(full), .empty(empty), .count(count),
        .resolve(resolve), .resolve_taken(resolve_taken), .resolve_target(resolve_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_outcome(upd_outcome),
`ifdef BRQ_STATS_EN
        .stat_resolved(stat_resolved), .stat_mispred(stat_mispred),
`endif
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] tgt;
    } ent_t;

    ent_t        q[$];
    logic        e_mis, e_uv, e_uo, e_uf;
    logic [31:0] e_red, e_upc;
    int          e_sres, e_smis;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("count", 32'(count), q.size());
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("mispredict", 32'(mispredict), 32'(e_mis));
        chk("redirect_pc", redirect_pc, e_red);
        chk("upd_valid", 32'(upd_valid), 32'(e_uv));
        chk("upd_pc", upd_pc, e_upc);
        chk("upd_outcome", 32'(upd_outcome), 32'(e_uo));
        chk("underflow", 32'(underflow), 32'(e_uf));
`ifdef BRQ_STATS_EN
        chk("stat_resolved", 32'(stat_resolved), e_sres);
        chk("stat_mispred", 32'(stat_mispred), e_smis);
`endif
    endtask

    task automatic do_reset(input bit p);
        reset = 1'b1; push = p; push_pc = 32'h777; push_pred = 1'b0; push_target = '0;
        resolve = p; resolve_taken = 1'b1; resolve_target = 32'h999;
        q.delete();
        e_mis = 0; e_uv = 0; e_uo = 0; e_uf = 0; e_red = 0; e_upc = 0; e_sres = 0; e_smis = 0;
        @(posedge clk); #1;
        chk_all();
        reset = 1'b0; push = 1'b0; resolve = 1'b0;
    endtask

    // One clock cycle: drive inputs, advance the model by the queue rules, compare after the edge.
    task automatic step(input bit p, input logic [31:0] pc, input bit pr, input logic [31:0] tg,
                        input bit r, input bit tk, input logic [31:0] rt);
        bit   pop, fl, was_full;
        ent_t h, n;
        push = p; push_pc = pc; push_pred = pr; push_target = tg;
        resolve = r; resolve_taken = tk; resolve_target = rt;

        was_full = (q.size() == DEPTH);
        pop = r && (q.size() > 0);
        fl  = 0;
        e_uv = pop;
        e_mis = 0;
        if (pop) begin
            h = q[0];
            fl = (tk != h.pred) || (tk && rt != h.tgt);
            e_upc = h.pc;
            e_uo  = tk;
            if (fl) begin
                e_mis = 1;
                e_red = tk ? rt : h.pc + 32'd4;
            end
            if (e_sres < 16'hFFFF) e_sres++;
            if (fl && e_smis < 16'hFFFF) e_smis++;
        end
        if (r && q.size() == 0) e_uf = 1;
        if (pop) void'(q.pop_front());
        if (fl) q.delete();
        if (p && (!was_full || pop) && !fl) begin
            n.pc = pc; n.pred = pr; n.tgt = tg;
            q.push_back(n);
        end

        @(posedge clk); #1;
        chk_all();
        push = 1'b0; resolve = 1'b0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [31:0] tset[4];

    initial begin
        tset[0] = 32'h1000; tset[1] = 32'h1004; tset[2] = 32'h2000; tset[3] = 32'hFFFF_FFFC;
        reset = 1'b1; push = 0; push_pc = 0; push_pred = 0; push_target = 0;
        resolve = 0; resolve_taken = 0; resolve_target = 0;
        do_reset(0);

        // correct not-taken prediction
        step(1, 32'h100, 0, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("t1_upd_pc", upd_pc, 32'h100);
        chk("t1_mis", 32'(mispredict), 32'h0);
        idle();

        // predicted not-taken, actually taken
        step(1, 32'h200, 0, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 32'h240);
        chk("t2_redirect", redirect_pc, 32'h240);
        chk("t2_mis", 32'(mispredict), 32'h1);

        // predicted taken, actually not-taken; younger entry flushed
        step(1, 32'h300, 1, 32'h380, 0, 0, 0);
        step(1, 32'h304, 0, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("t3_redirect", redirect_pc, 32'h304);
        chk("t3_count", 32'(count), 32'h0);

        // fill, drop on full, push+pop when full, drain across wrap
        for (int i = 0; i < 4; i++) step(1, 32'h400 + 32'(4*i), 0, 0, 0, 0, 0);
        chk("t4_full", 32'(full), 32'h1);
        step(1, 32'h410, 0, 0, 0, 0, 0);
        step(1, 32'h414, 0, 0, 1, 0, 0);
        chk("t4_count", 32'(count), 32'h4);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0);
        chk("t4_last_pc", upd_pc, 32'h414);

        // right direction, wrong target; then resolve on empty
        step(1, 32'h500, 1, 32'h500, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 32'h504);
        chk("t5_redirect", redirect_pc, 32'h504);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("t5_underflow", 32'(underflow), 32'h1);
        idle();

        // reset with live entries and a concurrent push
        for (int i = 0; i < 3; i++) step(1, 32'h600 + 32'(4*i), 1, 32'h700, 0, 0, 0);
        do_reset(1);

        // random traffic, with an occasional reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset($urandom_range(0, 1) == 1);
            else step($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC, 1'($urandom),
                      tset[$urandom_range(0, 3)], $urandom_range(0, 1) == 1, 1'($urandom),
                      tset[$urandom_range(0, 3)]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
